// File: rtl/fetch_queue_if.sv
// Bundle of the icache, redirect and IF/ID signals around the fetch queue.
// master = the fetch stage, slave = its environment (icache + decode).
interface fetch_queue_if #(
   parameter int DEPTH = 4
);
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic              imemREN;
   logic [31:0]       imemaddr;
   logic              ihit;
   logic [31:0]       imemload;
   logic              redirect;
   logic [31:0]       redirect_pc;
   logic              stall;
   logic              ifid_valid;
   logic [31:0]       ifid_instr;
   logic [31:0]       ifid_pc;
   logic [31:0]       ifid_npc;
   logic              halt_seen;
   logic [CNT_W-1:0]  count;

   modport master (
      output imemREN, imemaddr, ifid_valid, ifid_instr, ifid_pc, ifid_npc,
             halt_seen, count,
      input  ihit, imemload, redirect, redirect_pc, stall
   );

   modport slave (
      input  imemREN, imemaddr, ifid_valid, ifid_instr, ifid_pc, ifid_npc,
             halt_seen, count,
      output ihit, imemload, redirect, redirect_pc, stall
   );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch stage: sequential PC generation, icache requests and a
// DEPTH-entry prefetch FIFO of {pc, npc, instr} feeding IF/ID.
module fetch_queue #(
   parameter logic [31:0] PC_INIT = 32'h0,
   parameter int          DEPTH   = 4,
   parameter logic [5:0]  HALT_OP = 6'h3F
) (
   input  logic          CLK,
   input  logic          nRST,
   fetch_queue_if.master bus
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);

   typedef enum logic {FETCH, HALTED} state_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] npc;
      logic [31:0] instr;
   } entry_t;

   state_t           state_reg, state_next;
   logic [31:0]      pc_reg, pc_next;
   logic [CNT_W-1:0] count_reg, count_next;
   logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
   logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;

   entry_t           mem [DEPTH];
   entry_t           head;

   logic             ren;
   logic             valid;
   logic             push;
   logic             pop;
   logic [31:0]      pc_plus4;
   logic             unused_redirect_bits;

   assign unused_redirect_bits = ^bus.redirect_pc[1:0];

   always_comb begin
      valid    = (count_reg != '0);
      ren      = (state_reg == FETCH) && (count_reg < CNT_W'(DEPTH));
      push     = ren && bus.ihit && !bus.redirect;
      pop      = valid && !bus.stall && !bus.redirect;
      pc_plus4 = pc_reg + 32'd4;
   end

   always_comb begin
      state_next  = state_reg;
      pc_next     = pc_reg;
      count_next  = count_reg;
      rd_ptr_next = rd_ptr_reg;
      wr_ptr_next = wr_ptr_reg;
      if (bus.redirect) begin
         // Flush wins over any same-cycle hit or pop.
         state_next  = FETCH;
         pc_next     = {bus.redirect_pc[31:2], 2'b00};
         count_next  = '0;
         rd_ptr_next = '0;
         wr_ptr_next = '0;
      end else begin
         if (push) begin
            wr_ptr_next = wr_ptr_reg + PTR_W'(1);
            pc_next     = pc_plus4;
            if (bus.imemload[31:26] == HALT_OP) begin
               state_next = HALTED;
            end
         end
         if (pop) begin
            rd_ptr_next = rd_ptr_reg + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   count_next = count_reg + CNT_W'(1);
            2'b01:   count_next = count_reg - CNT_W'(1);
            default: count_next = count_reg;
         endcase
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_reg  <= FETCH;
         pc_reg     <= PC_INIT;
         count_reg  <= '0;
         rd_ptr_reg <= '0;
         wr_ptr_reg <= '0;
      end else begin
         state_reg  <= state_next;
         pc_reg     <= pc_next;
         count_reg  <= count_next;
         rd_ptr_reg <= rd_ptr_next;
         wr_ptr_reg <= wr_ptr_next;
      end
   end

   // Storage needs no reset: every read is qualified by a nonzero count.
   always_ff @(posedge CLK) begin
      if (push) begin
         mem[wr_ptr_reg] <= '{pc: pc_reg, npc: pc_plus4, instr: bus.imemload};
      end
   end

   assign head           = mem[rd_ptr_reg];
   assign bus.imemREN    = ren;
   assign bus.imemaddr   = pc_reg;
   assign bus.ifid_valid = valid;
   assign bus.ifid_instr = valid ? head.instr : 32'h0;
   assign bus.ifid_pc    = valid ? head.pc    : 32'h0;
   assign bus.ifid_npc   = valid ? head.npc   : 32'h0;
   assign bus.halt_seen  = (state_reg == HALTED);
   assign bus.count      = count_reg;
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: stimulus queues the expected pops, a
// negedge monitor checks every entry decode actually consumes.
module tb_fetch_queue;
   logic CLK;
   logic nRST;
   logic halt_en;

   int n_checks;
   int n_fail;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
   } exp_t;

   exp_t sb[$];

   fetch_queue_if #(.DEPTH(4)) bus ();

   fetch_queue #(
      .PC_INIT (32'h0),
      .DEPTH   (4),
      .HALT_OP (6'h3F)
   ) dut (
      .CLK  (CLK),
      .nRST (nRST),
      .bus  (bus)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   function automatic logic [31:0] word_at(input logic [31:0] a, input logic h);
      if (h && a == 32'h8) return 32'hFFFF_FFFF;
      return 32'h1000_0000 + a;
   endfunction

   // icache model: data for whatever address is presented
   always_comb bus.imemload = word_at(bus.imemaddr, halt_en);

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic push_exp(input logic [31:0] pc, input logic [31:0] instr);
      exp_t e;
      e.pc    = pc;
      e.instr = instr;
      sb.push_back(e);
   endtask

   always @(negedge CLK) begin
      if (nRST && bus.ifid_valid && !bus.stall && !bus.redirect) begin
         if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL pop_unexpected: got pc %h expected no pop", bus.ifid_pc);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("pop_pc", bus.ifid_pc, e.pc);
            check("pop_npc", bus.ifid_npc, e.pc + 32'd4);
            check("pop_instr", bus.ifid_instr, e.instr);
            $display("pop pc=%h npc=%h instr=%h", bus.ifid_pc, bus.ifid_npc, bus.ifid_instr);
         end
      end
   end

   task automatic check_reset_outputs(input string tag);
      check({tag, "_ren"}, 32'(bus.imemREN), 32'd1);
      check({tag, "_addr"}, bus.imemaddr, 32'h0);
      check({tag, "_valid"}, 32'(bus.ifid_valid), 32'd0);
      check({tag, "_instr"}, bus.ifid_instr, 32'h0);
      check({tag, "_pc"}, bus.ifid_pc, 32'h0);
      check({tag, "_npc"}, bus.ifid_npc, 32'h0);
      check({tag, "_halt"}, 32'(bus.halt_seen), 32'd0);
      check({tag, "_count"}, 32'(bus.count), 32'd0);
   endtask

   initial begin
      n_checks        = 0;
      n_fail          = 0;
      halt_en         = 1'b0;
      nRST            = 1'b0;
      bus.ihit        = 1'b0;
      bus.redirect    = 1'b0;
      bus.redirect_pc = 32'h0;
      bus.stall       = 1'b0;
      repeat (2) tick();
      check_reset_outputs("reset");

      // 1: streaming, one word per cycle, head one cycle behind the fetch PC
      for (int k = 0; k < 5; k++) push_exp(32'(4 * k), word_at(32'(4 * k), 1'b0));
      nRST     = 1'b1;
      bus.ihit = 1'b1;
      check("s1_addr0", bus.imemaddr, 32'h0);
      for (int j = 1; j <= 6; j++) begin
         tick();
         check("s1_addr", bus.imemaddr, 32'(4 * j));
         check("s1_count", 32'(bus.count), 32'd1);
         check("s1_head", bus.ifid_pc, 32'(4 * (j - 1)));
         $display("stream cycle %0d addr=%h head=%h", j, bus.imemaddr, bus.ifid_pc);
      end

      // 2: decode stalls, queue fills to DEPTH with the head held at 0x14
      bus.stall = 1'b1;
      for (int c = 2; c <= 4; c++) begin
         tick();
         check("s2_count", 32'(bus.count), 32'(c));
         check("s2_head", bus.ifid_pc, 32'h14);
      end
      check("s2_ren_full", 32'(bus.imemREN), 32'd0);
      check("s2_addr_full", bus.imemaddr, 32'h24);
      tick();
      check("s2_count_hold", 32'(bus.count), 32'd4);
      check("s2_addr_hold", bus.imemaddr, 32'h24);

      // 3: full queue, stall drops with ihit high: one pop, no push
      push_exp(32'h14, word_at(32'h14, 1'b0));
      bus.stall = 1'b0;
      tick();
      check("s3_count", 32'(bus.count), 32'd3);
      check("s3_ren", 32'(bus.imemREN), 32'd1);
      check("s3_head", bus.ifid_pc, 32'h18);

      // 4: redirect with count 3 and a same-cycle hit; low bits ignored
      bus.redirect    = 1'b1;
      bus.redirect_pc = 32'h0000_0103;
      tick();
      bus.redirect = 1'b0;
      check("s4_count", 32'(bus.count), 32'd0);
      check("s4_valid", 32'(bus.ifid_valid), 32'd0);
      check("s4_instr", bus.ifid_instr, 32'h0);
      check("s4_addr", bus.imemaddr, 32'h100);
      check("s4_ren", 32'(bus.imemREN), 32'd1);

      // restart at 0x100, then redirect to 0 where the HALT word lives
      push_exp(32'h100, word_at(32'h100, 1'b0));
      tick();
      check("s4_restart_head", bus.ifid_pc, 32'h100);
      tick();
      check("s4_restart_head2", bus.ifid_pc, 32'h104);
      halt_en         = 1'b1;
      bus.redirect    = 1'b1;
      bus.redirect_pc = 32'h0;
      tick();
      bus.redirect = 1'b0;
      bus.stall    = 1'b1;
      check("s5_addr0", bus.imemaddr, 32'h0);

      // 5: HALT at 0x8 is enqueued, fetch stops, queue drains
      repeat (3) tick();
      check("s5_count", 32'(bus.count), 32'd3);
      check("s5_halt", 32'(bus.halt_seen), 32'd1);
      check("s5_ren", 32'(bus.imemREN), 32'd0);
      check("s5_addr", bus.imemaddr, 32'hC);
      tick();
      check("s5_count_hold", 32'(bus.count), 32'd3);
      check("s5_addr_frozen", bus.imemaddr, 32'hC);
      push_exp(32'h0, word_at(32'h0, 1'b1));
      push_exp(32'h4, word_at(32'h4, 1'b1));
      push_exp(32'h8, 32'hFFFF_FFFF);
      bus.stall = 1'b0;
      repeat (3) tick();
      check("s5_drained", 32'(bus.count), 32'd0);
      check("s5_drain_valid", 32'(bus.ifid_valid), 32'd0);
      check("s5_halt_kept", 32'(bus.halt_seen), 32'd1);
      halt_en         = 1'b0;
      bus.redirect    = 1'b1;
      bus.redirect_pc = 32'h20;
      tick();
      bus.redirect = 1'b0;
      bus.stall    = 1'b1;
      check("s5_halt_clr", 32'(bus.halt_seen), 32'd0);
      check("s5_ren_back", 32'(bus.imemREN), 32'd1);
      check("s5_addr20", bus.imemaddr, 32'h20);

      // 6: asynchronous reset in mid-stream with two entries queued
      repeat (2) tick();
      check("s6_count2", 32'(bus.count), 32'd2);
      check("s6_head", bus.ifid_pc, 32'h20);
      check("s6_addr", bus.imemaddr, 32'h28);
      #2;
      nRST = 1'b0;
      #1;
      check_reset_outputs("async");
      repeat (2) tick();
      check("s6_in_reset_count", 32'(bus.count), 32'd0);
      #2;
      push_exp(32'h0, word_at(32'h0, 1'b0));
      push_exp(32'h4, word_at(32'h4, 1'b0));
      bus.stall = 1'b0;
      nRST      = 1'b1;
      check("s6_addr_init", bus.imemaddr, 32'h0);
      for (int j = 1; j <= 3; j++) begin
         tick();
         check("s6_head_after", bus.ifid_pc, 32'(4 * (j - 1)));
         check("s6_addr_after", bus.imemaddr, 32'(4 * j));
      end
      bus.stall = 1'b1;
      tick();
      check("sb_empty", 32'(sb.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
